uart_response_tx: RTL and testbench

UART_RESPONSE_TX -- requirements
Module: uart_response_tx

---
 rtl/usb_hid_pkg.sv | 81 ++++++++
 rtl/sync_fifo.sv | 75 +++++++
 rtl/uart_response_tx.sv | 172 +++++++++++++++++
 tb/tb_uart_response_tx.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_hid_pkg.sv
// Shared definitions for the response transmitter.
// Holds the response-code values, the message lengths, the serializer
// state encoding and the ASCII message ROM used by uart_response_tx.
package usb_hid_pkg;

  // Response codes as delivered by the command parser
  localparam logic [1:0] RSP_OK    = 2'd0;
  localparam logic [1:0] RSP_ERR   = 2'd1;
  localparam logic [1:0] RSP_BUSY  = 2'd2;
  localparam logic [1:0] RSP_READY = 2'd3;

  // Message lengths in bytes, trailing line feed included
  localparam logic [2:0] LEN_OK    = 3'd3;
  localparam logic [2:0] LEN_ERR   = 3'd4;
  localparam logic [2:0] LEN_BUSY  = 3'd5;
  localparam logic [2:0] LEN_READY = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  function automatic logic [2:0] msg_len(input logic [1:0] code);
    logic [2:0] len;
    case (code)
      RSP_OK:    len = LEN_OK;
      RSP_ERR:   len = LEN_ERR;
      RSP_BUSY:  len = LEN_BUSY;
      RSP_READY: len = LEN_READY;
      default:   len = LEN_OK;
    endcase
    return len;
  endfunction

  // Message ROM: byte idx of the message for a code; anything past the
  // text is the line feed, so the last byte falls out of the default arms.
  function automatic logic [7:0] msg_byte(input logic [1:0] code, input logic [2:0] idx);
    logic [7:0] b;
    case (code)
      RSP_OK: begin
        case (idx)
          3'd0:    b = 8'h4F;  // O
          3'd1:    b = 8'h4B;  // K
          default: b = 8'h0A;
        endcase
      end
      RSP_ERR: begin
        case (idx)
          3'd0:    b = 8'h45;  // E
          3'd1:    b = 8'h52;  // R
          3'd2:    b = 8'h52;  // R
          default: b = 8'h0A;
        endcase
      end
      RSP_BUSY: begin
        case (idx)
          3'd0:    b = 8'h42;  // B
          3'd1:    b = 8'h55;  // U
          3'd2:    b = 8'h53;  // S
          3'd3:    b = 8'h59;  // Y
          default: b = 8'h0A;
        endcase
      end
      RSP_READY: begin
        case (idx)
          3'd0:    b = 8'h52;  // R
          3'd1:    b = 8'h45;  // E
          3'd2:    b = 8'h41;  // A
          3'd3:    b = 8'h44;  // D
          3'd4:    b = 8'h59;  // Y
          default: b = 8'h0A;
        endcase
      end
      default: b = 8'h0A;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty flags.
// Ports: clk, rst_n (async active-low), wr_en/wr_data (write is dropped
// when full), rd_en (pop, ignored when empty), rd_data (head entry,
// valid while !empty), full, empty.
// Flags come from registered pointers only, so an entry written on an
// edge becomes visible to the reader in the following cycle.
module sync_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  // Pointers carry one extra wrap bit to tell full from empty
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_ok_s;
  logic             rd_ok_s;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
  assign wr_ok_s = wr_en && !full;
  assign rd_ok_s = rd_en && !empty;

  // Next-pointer computation
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_ok_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/uart_response_tx.sv
// Response transmitter: queues 2-bit response codes and sends the
// matching ASCII message over an 8N1 UART line.
// Ports: clk_60mhz (sole clock), rst_n (async active-low),
// rsp_valid/rsp_code (request from the parser), rsp_ready (queue not
// full), uart_tx (registered serial out, idle high), tx_busy (message in
// flight or codes waiting).
module uart_response_tx
  import usb_hid_pkg::*;
#(
  parameter int CLKS_PER_BIT = 521,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk_60mhz,
  input  logic       rst_n,
  input  logic       rsp_valid,
  input  logic [1:0] rsp_code,
  output logic       rsp_ready,
  output logic       uart_tx,
  output logic       tx_busy
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TIMER_ONE    = TW'(1);

  tx_state_e   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]  bit_q, bit_d;
  logic [2:0]  byte_q, byte_d;
  logic [1:0]  code_q, code_d;
  // A code has been popped and the next edge starts its first byte
  logic        pending_q, pending_d;
  logic        tx_q, tx_d;

  logic        push_s;
  logic        pop_s;
  logic        full_s;
  logic        empty_s;
  logic [1:0]  head_code_s;
  logic        bit_done_s;
  logic        last_byte_s;
  logic [2:0]  len_s;
  logic [7:0]  cur_byte_s;

  assign rsp_ready   = !full_s;
  assign push_s      = rsp_valid && rsp_ready;
  assign bit_done_s  = (timer_q == '0);
  assign len_s       = msg_len(code_q);
  assign last_byte_s = (byte_q == (len_s - 3'd1));
  assign cur_byte_s  = msg_byte(code_q, byte_q);
  assign uart_tx     = tx_q;
  assign tx_busy     = (state_q != ST_IDLE) || pending_q || !empty_s;

  sync_fifo #(
    .WIDTH (2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_60mhz),
    .rst_n   (rst_n),
    .wr_en   (push_s),
    .wr_data (rsp_code),
    .rd_en   (pop_s),
    .rd_data (head_code_s),
    .full    (full_s),
    .empty   (empty_s)
  );

  // Message sequencer and bit serializer next-state logic
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    code_d    = code_q;
    pending_d = pending_q;
    pop_s     = 1'b0;
    tx_d      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (pending_q) begin
          state_d   = ST_START;
          timer_d   = TIMER_RELOAD;
          bit_d     = 3'd0;
          byte_d    = 3'd0;
          pending_d = 1'b0;
        end else if (!empty_s) begin
          pop_s     = 1'b1;
          pending_d = 1'b1;
          code_d    = head_code_s;
        end else begin
          pending_d = 1'b0;
        end
      end
      ST_START: begin
        if (bit_done_s) begin
          state_d = ST_DATA;
          timer_d = TIMER_RELOAD;
          bit_d   = 3'd0;
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end
      ST_DATA: begin
        if (bit_done_s) begin
          timer_d = TIMER_RELOAD;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end
      ST_STOP: begin
        if (bit_done_s) begin
          if (last_byte_s) begin
            // Popping here leaves exactly one idle cycle before the next message
            state_d = ST_IDLE;
            timer_d = '0;
            byte_d  = 3'd0;
            if (!empty_s) begin
              pop_s     = 1'b1;
              pending_d = 1'b1;
              code_d    = head_code_s;
            end else begin
              pending_d = 1'b0;
            end
          end else begin
            state_d = ST_START;
            timer_d = TIMER_RELOAD;
            byte_d  = byte_q + 3'd1;
          end
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Line level follows the state being entered so uart_tx is a plain flop
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = cur_byte_s[bit_d];
      default:  tx_d = 1'b1;
    endcase
  end

  // Serializer state registers; reset forces the line high immediately
  always_ff @(posedge clk_60mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      bit_q     <= 3'd0;
      byte_q    <= 3'd0;
      code_q    <= 2'd0;
      pending_q <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      code_q    <= code_d;
      pending_q <= pending_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_response_tx.sv
// Self-checking bench for uart_response_tx: a fast instance (4 clocks per
// bit) covers sequencing, queueing and reset; a default-parameter
// instance covers one OK message at full bit length.
module tb_uart_response_tx;

  localparam int CPB_A = 4;
  localparam int CPB_B = 521;

  typedef struct {
    logic [1:0] code;
    string      msg;
    int         clocks;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_a_n, rst_b_n;
  logic       rsp_valid, sel;
  logic [1:0] rsp_code;
  logic       valid_a, valid_b;
  logic       ready_a, ready_b, tx_a, tx_b, busy_a, busy_b;
  logic       m_ready, m_busy, mon_tx;
  int         mon_cpb;
  int         cyc = 0;
  int         n_pass = 0;
  int         n_total = 0;
  logic [7:0] rx_q [$];
  vec_t       vecs [9];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign valid_a = rsp_valid & ~sel;
  assign valid_b = rsp_valid & sel;
  assign m_ready = sel ? ready_b : ready_a;
  assign m_busy  = sel ? busy_b : busy_a;
  assign mon_tx  = sel ? tx_b : tx_a;
  assign mon_cpb = sel ? CPB_B : CPB_A;

  uart_response_tx #(.CLKS_PER_BIT(CPB_A), .FIFO_DEPTH(4)) u_dut_a (
    .clk_60mhz (clk), .rst_n (rst_a_n), .rsp_valid (valid_a), .rsp_code (rsp_code),
    .rsp_ready (ready_a), .uart_tx (tx_a), .tx_busy (busy_a)
  );

  uart_response_tx u_dut_b (
    .clk_60mhz (clk), .rst_n (rst_b_n), .rsp_valid (valid_b), .rsp_code (rsp_code),
    .rsp_ready (ready_b), .uart_tx (tx_b), .tx_busy (busy_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance n clocks and settle 1 ns past the edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a code and hold it until accepted; acc = edge index of accept
  task automatic push(input logic [1:0] c, output int acc);
    int waited;
    waited = 0;
    @(negedge clk);
    rsp_valid = 1'b1;
    rsp_code  = c;
    while (m_ready !== 1'b1 && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 5000) begin
      check("push_timeout", 32'd0, 32'd1);
      rsp_valid = 1'b0;
      acc = -1;
    end else begin
      @(posedge clk);
      #1;
      acc = cyc;
      rsp_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input int budget, output int fall);
    int n;
    n = 0;
    while (m_busy !== 1'b0 && n < budget) begin
      step(1);
      n++;
    end
    if (n >= budget) check("busy_timeout", 32'd0, 32'd1);
    fall = cyc;
  endtask

  task automatic check_msgs(input string name, input string exp);
    check({name, "_len"}, rx_q.size(), exp.len());
    for (int i = 0; i < exp.len(); i++) begin
      if (i < rx_q.size()) check(name, rx_q[i], exp[i]);
    end
    rx_q.delete();
  endtask

  task automatic set_vec(input int i, input logic [1:0] c, input string m, input int clocks);
    vecs[i].code   = c;
    vecs[i].msg    = m;
    vecs[i].clocks = clocks;
  endtask

  // UART monitor: detects a start bit, samples each bit at its middle
  initial begin
    int         cpb;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (mon_tx === 1'b0) begin
        cpb = mon_cpb;
        repeat (cpb / 2) @(negedge clk);
        if (mon_tx === 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (cpb) @(negedge clk);
            b[i] = mon_tx;
          end
          repeat (cpb) @(negedge clk);
          check("stop_bit", {31'd0, mon_tx}, 32'd1);
          rx_q.push_back(b);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc2, fall, e, lows;
    int accs [6];
    logic [1:0] full_codes [6];

    sel = 1'b0; rsp_valid = 1'b0; rsp_code = 2'd0;
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    step(3);
    check("rst_tx_a", tx_a, 1'b1);
    check("rst_ready_a", ready_a, 1'b1);
    check("rst_busy_a", busy_a, 1'b0);
    check("rst_tx_b", tx_b, 1'b1);
    check("rst_ready_b", ready_b, 1'b1);
    check("rst_busy_b", busy_b, 1'b0);
    @(negedge clk);
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    step(2);

    // Latency and bit length of a single OK message
    push(2'd0, acc);
    check("lat_accept_tx", tx_a, 1'b1);
    step(1);
    check("lat_pop_tx", tx_a, 1'b1);
    check("lat_pop_busy", busy_a, 1'b1);
    step(1);
    check("lat_start_edge", tx_a, 1'b0);
    step(3);
    check("start_hold", tx_a, 1'b0);
    step(1);
    check("ok_bit0", tx_a, 1'b1);
    wait_idle(1000, fall);
    check("ok_clocks", fall - acc, 32'd122);
    step(2);
    check_msgs("ok_msg", "OK\n");

    // Pointer wrap: nine single messages, each after the previous completes
    set_vec(0, 2'd0, "OK\n", 122);
    set_vec(1, 2'd1, "ERR\n", 162);
    set_vec(2, 2'd2, "BUSY\n", 202);
    set_vec(3, 2'd3, "READY\n", 242);
    set_vec(4, 2'd0, "OK\n", 122);
    set_vec(5, 2'd1, "ERR\n", 162);
    set_vec(6, 2'd2, "BUSY\n", 202);
    set_vec(7, 2'd3, "READY\n", 242);
    set_vec(8, 2'd0, "OK\n", 122);
    for (int i = 0; i < 9; i++) begin
      push(vecs[i].code, acc);
      wait_idle(1000, fall);
      check("wrap_clocks", fall - acc, vecs[i].clocks);
      step(2);
      check_msgs("wrap_msg", vecs[i].msg);
    end

    // Back-to-back ERR then READY with a single idle clock between them
    push(2'd1, acc);
    push(2'd3, acc2);
    check("b2b_accept", acc2 - acc, 32'd1);
    e = acc + 162;
    step(e - cyc);
    check("b2b_idle_tx", tx_a, 1'b1);
    check("b2b_idle_busy", busy_a, 1'b1);
    step(1);
    check("b2b_next_start", tx_a, 1'b0);
    wait_idle(1000, fall);
    check("b2b_clocks", fall - acc, 32'd403);
    step(2);
    check_msgs("b2b_msg", "ERR\nREADY\n");

    // Queue full: one code is popped at once, four more fill the queue,
    // the sixth waits for the pop at the end of the first message
    full_codes[0] = 2'd0; full_codes[1] = 2'd1; full_codes[2] = 2'd2;
    full_codes[3] = 2'd3; full_codes[4] = 2'd0; full_codes[5] = 2'd1;
    for (int i = 0; i < 6; i++) begin
      push(full_codes[i], accs[i]);
      if (i == 4) check("full_ready_low", ready_a, 1'b0);
    end
    check("full_burst", accs[4] - accs[0], 32'd4);
    check("full_held", accs[5] - accs[0], 32'd123);
    wait_idle(5000, fall);
    step(2);
    check_msgs("full_msg", "OK\nERR\nBUSY\nREADY\nOK\nERR\n");

    // Reset during data bit 3 of 'B' with a second code queued
    push(2'd2, acc);
    push(2'd0, acc2);
    step(acc + 19 - cyc);
    check("mid_bit3", tx_a, 1'b0);
    rst_a_n = 1'b0;
    #1;
    check("rst_mid_tx", tx_a, 1'b1);
    check("rst_mid_ready", ready_a, 1'b1);
    check("rst_mid_busy", busy_a, 1'b0);
    step(2);
    @(negedge clk);
    rst_a_n = 1'b1;
    step(60);
    rx_q.delete();
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (tx_a !== 1'b1) lows++;
      if (busy_a !== 1'b0) lows++;
    end
    check("no_resume", lows, 32'd0);
    check("no_frames", rx_q.size(), 32'd0);

    // Default parameters: one OK message at 521 clocks per bit
    sel = 1'b1;
    step(2);
    push(2'd0, acc);
    check("b_accept_tx", tx_b, 1'b1);
    step(2);
    check("b_start_edge", tx_b, 1'b0);
    step(520);
    check("b_start_hold", tx_b, 1'b0);
    step(1);
    check("b_bit0", tx_b, 1'b1);
    wait_idle(20000, fall);
    check("b_clocks", fall - acc, 32'd15632);
    step(2);
    check_msgs("b_msg", "OK\n");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
